// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI frame decoder driving a small byte register bank
// Frames are a command byte (W, INC, ADDR) followed by data bytes; MISO byte comes from tx_data.
module spi_cmd_ctrl #(
    parameter int          NREGS       = 4,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [7:0]           tx_data,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [5:0]           wr_addr,
    output logic                 err
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic        w_q, w_d;
    logic        inc_q, inc_d;
    logic [7:0]  tx_q, tx_d;
    logic        err_q, err_d;
    logic        strobe_q, strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic        we;
    logic [AW-1:0] we_idx;
    logic [5:0]  next_addr;
    logic [7:0]  regs_q [NREGS];

    function automatic logic in_range(input logic [5:0] a);
        return {1'b0, a} < 7'(NREGS);
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        w_d       = w_q;
        inc_d     = inc_q;
        tx_d      = tx_q;
        err_d     = err_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        we        = 1'b0;
        we_idx    = addr_q[AW-1:0];
        next_addr = addr_q;

        case (state_q)
            S_IDLE: begin
                tx_d = STATUS_BYTE;
                if (frame) begin
                    state_d = S_CMD;
                    err_d   = 1'b0;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    w_d     = rx_data[7];
                    inc_d   = rx_data[6];
                    addr_d  = rx_data[5:0];
                    state_d = S_DATA;
                    if (rx_data[7]) begin
                        tx_d = STATUS_BYTE;
                    end else if (in_range(rx_data[5:0])) begin
                        tx_d = regs_q[rx_data[AW-1:0]];
                    end else begin
                        tx_d  = 8'hFF;
                        err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (w_q) begin
                        if (in_range(addr_q)) begin
                            we        = 1'b1;
                            strobe_d  = 1'b1;
                            wr_addr_d = addr_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    next_addr = inc_q ? addr_q + 6'd1 : addr_q;
                    addr_d    = next_addr;
                    // Read data for the following slot is prefetched from the advanced address.
                    if (!w_q) begin
                        if (in_range(next_addr)) begin
                            tx_d = regs_q[next_addr[AW-1:0]];
                        end else begin
                            tx_d  = 8'hFF;
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving with the falling frame still commits; only the MISO byte and state reset.
        if (!frame && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tx_d    = STATUS_BYTE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            w_q       <= 1'b0;
            inc_q     <= 1'b0;
            tx_q      <= STATUS_BYTE;
            err_q     <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            w_q       <= w_d;
            inc_q     <= inc_d;
            tx_q      <= tx_d;
            err_q     <= err_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            if (we) begin
                regs_q[we_idx] <= rx_data;
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign tx_data   = tx_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = wr_addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

    localparam int         NREGS = 4;
    localparam logic [7:0] SB    = 8'hA5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 frame;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic [7:0]           tx_data;
    logic [8*NREGS-1:0]   regs_flat;
    logic                 wr_strobe;
    logic [5:0]           wr_addr;
    logic                 err;

    spi_cmd_ctrl #(.NREGS(NREGS), .STATUS_BYTE(SB)) dut (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int strobe_cnt = 0;

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        frame = 1'b1;
        tick(); tick();
    endtask

    task automatic end_frame();
        frame = 1'b0;
        tick(); tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    typedef struct {
        logic [7:0]  b [6];
        int          n;
        logic [31:0] regs;
        logic        err;
        int          strobes;
        logic [7:0]  tx;
    } vec_t;

    vec_t        vt [6];
    int          s0;
    logic [7:0]  last_tx;
    logic [7:0]  m_regs [NREGS];
    logic        m_err;
    logic [31:0] mpack;
    logic [7:0]  cmd, b;
    logic [5:0]  a0, a, na;
    logic        exp_stb;
    int          nd;

    initial begin
        vt[0] = '{b: '{8'h80, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, regs: 32'h0000000F, err: 1'b0, strobes: 1, tx: SB};
        vt[1] = '{b: '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, n: 6, regs: 32'h44332211, err: 1'b1, strobes: 4, tx: SB};
        vt[2] = '{b: '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, regs: 32'h00000000, err: 1'b1, strobes: 0, tx: 8'hFF};
        vt[3] = '{b: '{8'h83, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00}, n: 3, regs: 32'hBB000000, err: 1'b0, strobes: 2, tx: SB};
        vt[4] = '{b: '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 5, regs: 32'h00000000, err: 1'b1, strobes: 0, tx: 8'hFF};
        vt[5] = '{b: '{8'hFF, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00}, n: 3, regs: 32'h00000034, err: 1'b1, strobes: 1, tx: SB};

        do_reset();
        chk("reset_tx", tx_data, SB);
        chk("reset_regs", regs_flat, 32'h0);
        chk("reset_strobe", wr_strobe, 1'b0);
        chk("reset_wr_addr", wr_addr, 6'd0);
        chk("reset_err", err, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            s0 = strobe_cnt;
            start_frame();
            last_tx = 8'h00;
            for (int k = 0; k < vt[i].n; k++) begin
                send(vt[i].b[k]);
                gap(3);
                last_tx = tx_data;
            end
            chk($sformatf("vec%0d_tx", i), last_tx, vt[i].tx);
            end_frame();
            chk($sformatf("vec%0d_regs", i), regs_flat, vt[i].regs);
            chk($sformatf("vec%0d_err", i), err, vt[i].err);
            chk($sformatf("vec%0d_strobes", i), strobe_cnt - s0, vt[i].strobes);
            chk($sformatf("vec%0d_tx_idle", i), tx_data, SB);
        end

        // Read-back with a preset register.
        do_reset();
        start_frame(); send(8'h82); gap(3); send(8'h3C); gap(3); end_frame();
        start_frame();
        send(8'h02);
        chk("read_tx_cmd", tx_data, 8'h3C);
        gap(3); send(8'h00); gap(3);
        chk("read_tx_held", tx_data, 8'h3C);
        end_frame();
        chk("read_tx_after", tx_data, SB);
        chk("read_err", err, 1'b0);

        // Abort mid-byte, then a stray rx_valid while idle.
        s0 = strobe_cnt;
        start_frame(); send(8'h81); gap(3);
        rx_data = 8'h99; frame = 1'b0;
        tick();
        chk("abort_tx", tx_data, SB);
        tick();
        rx_valid = 1'b1; rx_data = 8'h66; tick(); rx_valid = 1'b0; gap(3);
        chk("abort_strobes", strobe_cnt - s0, 0);
        chk("abort_regs", regs_flat, 32'h003C0000);

        // err stays set after frame end until the next frame begins.
        start_frame();
        send(8'hC0); gap(3);
        for (int k = 1; k <= 5; k++) begin send(8'(k * 8'h11)); gap(3); end
        end_frame();
        chk("err_held", err, 1'b1);
        tick();
        chk("err_held2", err, 1'b1);
        frame = 1'b1; tick();
        chk("err_clear", err, 1'b0);
        end_frame();

        // Back-to-back bytes.
        do_reset();
        start_frame(); send(8'hC0); gap(3);
        s0 = strobe_cnt;
        rx_valid = 1'b1; rx_data = 8'h01; tick();
        chk("b2b_stb0", wr_strobe, 1'b1);
        chk("b2b_addr0", wr_addr, 6'd0);
        rx_data = 8'h02; tick();
        chk("b2b_stb1", wr_strobe, 1'b1);
        chk("b2b_addr1", wr_addr, 6'd1);
        rx_valid = 1'b0; tick();
        chk("b2b_stb_off", wr_strobe, 1'b0);
        end_frame();
        chk("b2b_regs", regs_flat, 32'h00000201);
        chk("b2b_count", strobe_cnt - s0, 2);

        // Byte arriving in the same cycle frame falls.
        start_frame(); send(8'h80); gap(3);
        rx_valid = 1'b1; rx_data = 8'h77; frame = 1'b0; tick();
        rx_valid = 1'b0;
        chk("fall_stb", wr_strobe, 1'b1);
        chk("fall_regs", regs_flat, 32'h00000277);
        tick();
        chk("fall_tx", tx_data, SB);

        // Reset mid-burst.
        start_frame(); send(8'hC0); gap(3); send(8'h11); gap(3);
        chk("rst_pre", regs_flat, 32'h00000211);
        rst = 1'b1; tick();
        chk("rst_regs", regs_flat, 32'h0);
        chk("rst_tx", tx_data, SB);
        chk("rst_stb", wr_strobe, 1'b0);
        chk("rst_addr", wr_addr, 6'd0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        tick(); tick();
        send(8'h80); gap(3); send(8'h0F);
        chk("rst_after_stb", wr_strobe, 1'b1);
        gap(3); end_frame();
        chk("rst_after_regs", regs_flat, 32'h0000000F);

        // Randomized frames against a position-based model.
        do_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        for (int f = 0; f < 40; f++) begin
            cmd[7]   = 1'($urandom_range(0, 1));
            cmd[6]   = 1'($urandom_range(0, 1));
            cmd[5:0] = ($urandom_range(0, 3) == 0) ? 6'(60 + $urandom_range(0, 3)) : 6'($urandom_range(0, 7));
            a0 = cmd[5:0];
            nd = $urandom_range(0, 5);
            m_err = 1'b0;
            start_frame();
            send(cmd);
            if (!cmd[7] && a0 >= NREGS) m_err = 1'b1;
            chk($sformatf("rnd%0d_cmd_tx", f), tx_data,
                cmd[7] ? SB : (a0 < NREGS ? m_regs[a0[1:0]] : 8'hFF));
            gap($urandom_range(3, 5));
            for (int k = 0; k < nd; k++) begin
                b  = 8'($urandom);
                a  = cmd[6] ? 6'((a0 + k) % 64) : a0;
                na = cmd[6] ? 6'((a0 + k + 1) % 64) : a0;
                exp_stb = cmd[7] && (a < NREGS);
                if (exp_stb) m_regs[a[1:0]] = b;
                else if (cmd[7]) m_err = 1'b1;
                if (!cmd[7] && na >= NREGS) m_err = 1'b1;
                send(b);
                chk($sformatf("rnd%0d_%0d_stb", f, k), wr_strobe, exp_stb);
                if (exp_stb) chk($sformatf("rnd%0d_%0d_waddr", f, k), wr_addr, a);
                chk($sformatf("rnd%0d_%0d_tx", f, k), tx_data,
                    cmd[7] ? SB : (na < NREGS ? m_regs[na[1:0]] : 8'hFF));
                gap($urandom_range(3, 5));
            end
            end_frame();
            for (int i = 0; i < NREGS; i++) mpack[8*i +: 8] = m_regs[i];
            chk($sformatf("rnd%0d_regs", f), regs_flat, mpack);
            chk($sformatf("rnd%0d_err", f), err, m_err);
            chk($sformatf("rnd%0d_tx_idle", f), tx_data, SB);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
